rf_write_arbiter: RTL and testbench

Shares the single register-file write port between two writeback requesters. Requester A is the ALU/data-processing result; requester B is the load or link-register (R14) result. Grants at most one write per cycle using round-robin priority. Drives a registered write stage: 4-bit address, one-hot 16-bit write enable, 32-bit data, plus a PC-write flag when R15 is written.

---
 rtl/rf_write_arbiter_pkg.sv | 16 +
 rtl/rf_write_arbiter_if.sv | 33 +++
 rtl/rf_wr_onehot.sv | 18 +
 rtl/rf_write_arbiter.sv | 86 ++++++++
 tb/tb_rf_write_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and requester-id encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;
    localparam int PC_IDX = 15;
    localparam int LR_IDX = 14;

    // Identity of the requester that won the most recent transfer.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage : rf_write_arbiter_pkg

// File: rtl/rf_write_arbiter_if.sv
// Request/grant handshake and registered write stage of the register-file write port.
interface rf_write_arbiter_if;
    import rf_write_arbiter_pkg::*;

    logic              hold;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [NREG-1:0]   wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              pc_write;
    logic              conflict;

    // Arbiter side.
    modport slave (
        input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_valid, wr_addr, wr_en, wr_data, pc_write, conflict
    );

    // Requester / register-file side.
    modport master (
        output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_valid, wr_addr, wr_en, wr_data, pc_write, conflict
    );

endinterface : rf_write_arbiter_if

// File: rtl/rf_wr_onehot.sv
// Parameterized address-to-one-hot decoder with enable; all zero when disabled.
module rf_wr_onehot #(
    parameter int ADDR_W = 4,
    parameter int NREG   = 1 << ADDR_W
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NREG-1:0]   o_onehot
);

    // One comparator per enable line.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_addr == ADDR_W'(gi));
        end
    endgenerate

endmodule : rf_wr_onehot

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// result (A) and the load/link result (B), with a one-cycle registered write stage.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   bus
);

    req_id_e           r_last_grant;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [NREG-1:0]   r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_pc_write;
    logic              r_conflict;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_grant_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_en_next;
    logic              w_same_addr;

    // A wins when alone or when B had the last turn; B symmetrically. hold blocks both.
    assign w_grant_a   = !bus.hold && bus.a_valid && (!bus.b_valid || (r_last_grant == REQ_B));
    assign w_grant_b   = !bus.hold && bus.b_valid && (!bus.a_valid || (r_last_grant == REQ_A));
    assign w_grant_any = w_grant_a || w_grant_b;
    assign w_sel_addr  = w_grant_b ? bus.b_addr : bus.a_addr;
    assign w_sel_data  = w_grant_b ? bus.b_data : bus.a_data;
    assign w_same_addr = bus.a_valid && bus.b_valid && (bus.a_addr == bus.b_addr);

    assign bus.a_ready = w_grant_a;
    assign bus.b_ready = w_grant_b;

    rf_wr_onehot #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_onehot (
        .i_en     (w_grant_any),
        .i_addr   (w_sel_addr),
        .o_onehot (w_en_next)
    );

    // Write stage: valid/enable/pc flag follow the grant; address and data only load on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_en    <= '0;
            r_wr_data  <= '0;
            r_pc_write <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_wr_valid <= w_grant_any;
            r_wr_en    <= w_en_next;
            r_pc_write <= w_grant_any && (w_sel_addr == ADDR_W'(PC_IDX));
            r_conflict <= w_same_addr;
            if (w_grant_any) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // Round-robin pointer: remembers the last requester that completed a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_B;
        end else if (w_grant_a) begin
            r_last_grant <= REQ_A;
        end else if (w_grant_b) begin
            r_last_grant <= REQ_B;
        end
    end

    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_data  = r_wr_data;
    assign bus.pc_write = r_pc_write;
    assign bus.conflict = r_conflict;

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench: directed scenarios then randomized requesters against a behavioural model.
module tb_rf_write_arbiter;

    logic clk;
    logic rst_n;

    rf_write_arbiter_if bus ();

    rf_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int          m_last;      // 0 = A had the last turn, 1 = B
    int          m_addr;
    logic [31:0] m_data;
    bit          last_ga;
    bit          last_gb;
    int          a_wait;
    int          b_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_addr = 0;
        m_data = '0;
        last_ga = 0;
        last_gb = 0;
    endtask

    // One clock cycle: inputs already driven; check grants, clock, check write stage.
    task automatic cycle();
        bit ga, gb, ev, econf;
        bit av, bv;
        int ea;
        logic [31:0] ed;
        #1;
        av = bus.a_valid;
        bv = bus.b_valid;
        ga = 0;
        gb = 0;
        if (!bus.hold) begin
            if (av && !bv)      ga = 1;
            else if (bv && !av) gb = 1;
            else if (av && bv) begin
                if (m_last == 1) ga = 1;
                else             gb = 1;
            end
        end
        chk("a_ready", 32'(bus.a_ready), 32'(ga));
        chk("b_ready", 32'(bus.b_ready), 32'(gb));
        ev    = ga || gb;
        ea    = ga ? int'(bus.a_addr) : int'(bus.b_addr);
        ed    = ga ? bus.a_data : bus.b_data;
        econf = av && bv && (bus.a_addr == bus.b_addr);
        @(posedge clk);
        #1;
        if (ev) begin
            m_addr = ea;
            m_data = ed;
            m_last = ga ? 0 : 1;
        end
        last_ga = ga;
        last_gb = gb;
        chk("wr_valid", 32'(bus.wr_valid), 32'(ev));
        chk("wr_en", 32'(bus.wr_en), ev ? (32'd1 << m_addr) : 32'd0);
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
        chk("wr_data", bus.wr_data, m_data);
        chk("pc_write", 32'(bus.pc_write), 32'(ev && (m_addr == 15)));
        chk("conflict", 32'(bus.conflict), 32'(econf));
    endtask

    task automatic clear_inputs();
        bus.hold    = 0;
        bus.a_valid = 0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_conflict", 32'(bus.conflict), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Idle after reset, then first tie goes to A.
        cycle();
        bus.a_valid = 1; bus.a_addr = 4'd2; bus.a_data = 32'hAAAA0002;
        bus.b_valid = 1; bus.b_addr = 4'd5; bus.b_data = 32'hBBBB0005;
        cycle();
        chk("first_tie_a", 32'(last_ga), 32'd1);
        bus.a_valid = 0;
        cycle();
        chk("then_b", 32'(last_gb), 32'd1);
        bus.b_valid = 0;

        // A alone to r3.
        bus.a_valid = 1; bus.a_addr = 4'd3; bus.a_data = 32'h12345678;
        cycle();
        chk("a3_wr_en", 32'(bus.wr_en), 32'h0008);
        chk("a3_wr_data", bus.wr_data, 32'h12345678);
        bus.a_valid = 0;

        // B writes the PC.
        bus.b_valid = 1; bus.b_addr = 4'd15; bus.b_data = 32'h00000100;
        cycle();
        chk("pc_wr_en", 32'(bus.wr_en), 32'h8000);
        chk("pc_flag", 32'(bus.pc_write), 32'd1);
        bus.b_valid = 0;
        cycle();
        chk("pc_flag_drop", 32'(bus.pc_write), 32'd0);

        // Sustained dual requests alternate A, B, A, B.
        bus.a_valid = 1; bus.a_addr = 4'd1;  bus.a_data = 32'h0000_00A1;
        bus.b_valid = 1; bus.b_addr = 4'd14; bus.b_data = 32'h0000_00BE;
        cycle(); chk("alt0", 32'(bus.wr_en), 32'h0002);
        cycle(); chk("alt1", 32'(bus.wr_en), 32'h4000);
        cycle(); chk("alt2", 32'(bus.wr_en), 32'h0002);
        cycle(); chk("alt3", 32'(bus.wr_en), 32'h4000);

        // Same destination from both: conflict flagged, serialized.
        bus.a_addr = 4'd7; bus.a_data = 32'hC0FFEE07;
        bus.b_addr = 4'd7; bus.b_data = 32'hBEEF0007;
        cycle();
        chk("conf_flag", 32'(bus.conflict), 32'd1);
        chk("conf_en0", 32'(bus.wr_en), 32'h0080);
        if (last_ga) bus.a_valid = 0;
        else         bus.b_valid = 0;
        cycle();
        chk("conf_en1", 32'(bus.wr_en), 32'h0080);
        chk("conf_clear", 32'(bus.conflict), 32'd0);
        clear_inputs();

        // hold freezes grants; released request goes through.
        bus.a_valid = 1; bus.a_addr = 4'd9; bus.a_data = 32'h99990009;
        bus.hold = 1;
        repeat (3) begin
            cycle();
            chk("hold_idle", 32'(bus.wr_valid), 32'd0);
        end
        bus.hold = 0;
        cycle();
        chk("hold_release", 32'(bus.wr_en), 32'h0200);

        // Asynchronous reset drops an in-flight write immediately.
        bus.a_addr = 4'd6; bus.a_data = 32'h66660006;
        cycle();
        chk("pre_rst_valid", 32'(bus.wr_valid), 32'd1);
        rst_n = 0;
        #1;
        chk("async_rst_valid", 32'(bus.wr_valid), 32'd0);
        chk("async_rst_en", 32'(bus.wr_en), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        bus.b_valid = 1; bus.b_addr = 4'd4; bus.b_data = 32'h44440004;
        cycle();
        chk("post_rst_tie_a", 32'(last_ga), 32'd1);
        clear_inputs();

        // Randomized requesters obeying the valid/ready hold rule.
        a_wait = 0;
        b_wait = 0;
        last_ga = 0;
        last_gb = 0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.a_valid || last_ga) begin
                bus.a_valid = ($urandom_range(0, 2) != 0);
                bus.a_addr  = 4'($urandom_range(0, 15));
                bus.a_data  = $urandom;
            end
            if (!bus.b_valid || last_gb) begin
                bus.b_valid = ($urandom_range(0, 2) != 0);
                bus.b_addr  = ($urandom_range(0, 3) == 0) ? bus.a_addr : 4'($urandom_range(0, 15));
                bus.b_data  = $urandom;
            end
            bus.hold = ($urandom_range(0, 6) == 0);
            cycle();
            if (bus.a_valid && !bus.hold && !last_ga) a_wait++;
            else if (last_ga || !bus.a_valid)         a_wait = 0;
            if (bus.b_valid && !bus.hold && !last_gb) b_wait++;
            else if (last_gb || !bus.b_valid)         b_wait = 0;
            chk("a_starve", 32'(a_wait > 1), 32'd0);
            chk("b_starve", 32'(b_wait > 1), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rf_write_arbiter
